// File: rtl/uart_ctrl_pkg.sv
// Shared types and width helpers for the UART transmit scheduler.
// States follow the single-frame lifecycle: arbitrate, start, wait busy, wait done, gap.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_e;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One counter serves both the busy timeout and the inter-frame gap.
  function automatic int cnt_width(input int gap, input int timeout);
    int m;
    m = (gap > timeout) ? gap : timeout;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, modulo NUM_REQ.
// Zero latency; no internal state, the caller owns and advances the pointer.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  int win;
  int j;

  // Scan from farthest to nearest so the last hit is the closest one to ptr.
  always_comb begin
    win = -1;
    j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) win = j;
    end
    grant     = '0;
    grant_idx = '0;
    grant_vld = (win >= 0);
    if (win >= 0) begin
      grant[win] = 1'b1;
      grant_idx  = ID_W'(win);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ producers; byte accepted in cycle N gives tx_start at N+1.
// Backpressure: req_ready only in IDLE with tx_busy low; producers wait through the frame and gap.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int ID_W         = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  localparam int CNT_W = cnt_width(GAP_CYCLES, BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               tx_start_q, tx_start_d;
  logic               timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_vld;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // rst_n gates the handshake so nothing is accepted while reset is held.
  assign accept    = (state_q == IDLE) && !tx_busy && rst_n && arb_vld;
  assign req_ready = accept ? arb_grant : '0;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d  = req_data[arb_idx*DATA_W +: DATA_W];
          grant_id_d = arb_idx;
          ptr_d      = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          tx_start_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (GAP_CYCLES <= 1 || cnt_q == GAP_LAST) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign active      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: cycle-level reference of grant timing and order plus a transmitter model.
module tb_uart_tx_scheduler;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int GAP      = 2;
  localparam int TO       = 16;
  localparam int BUSY_LEN = 10;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            active;
  logic            timeout_err;

  uart_tx_scheduler #(
    .NUM_REQ      (N),
    .DATA_W       (DW),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: cycle index, pointer, when the scheduler is free again, expected pulses.
  int cyc = 0;
  int ptr = 0;
  int free_at = 0;
  int start_at = -1;
  int to_at = -1;
  int busy_from = 1;
  int busy_to = 0;
  int last_acc = -1;
  int n_to = 0;
  logic [7:0]  exp_data;
  logic [31:0] exp_gid;
  logic        never_busy = 1'b0;
  logic        auto_drop  = 1'b1;
  logic [N-1:0]    v = '0;
  logic [N*DW-1:0] d = '0;
  int wait_cnt [N];
  int glog [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy;
    int w;
    int j;
    @(negedge clk);
    cyc++;
    tx_busy = !never_busy && (cyc >= busy_from) && (cyc <= busy_to);
    for (int i = 0; i < N; i++) if (!v[i]) wait_cnt[i] = 0;
    req_valid = v;
    req_data  = d;
    #1;
    exp_rdy = '0;
    w = -1;
    if (rst_n && cyc >= free_at && !tx_busy) begin
      for (int k = 0; k < N; k++) begin
        j = (ptr + k) % N;
        if (w < 0 && v[j]) w = j;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("ready", 32'(req_ready), 32'(exp_rdy));
    check("tx_start", 32'(tx_start), 32'(cyc == start_at));
    check("timeout_err", 32'(timeout_err), 32'(cyc == to_at));
    check("active", 32'(active), 32'(rst_n && cyc < free_at));
    check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    if (req_ready != '0) check("ready_in_idle", 32'(active), 32'd0);
    if (cyc == start_at) begin
      check("tx_data", 32'(tx_data), 32'(exp_data));
      check("grant_id", 32'(grant_id), exp_gid);
    end
    if (timeout_err) n_to++;
    if (tx_start) begin
      busy_from = cyc + 1;
      busy_to   = cyc + BUSY_LEN;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i] && req_ready[i]) begin
        for (int k = 0; k < N; k++) begin
          if (k != i && v[k]) begin
            wait_cnt[k]++;
            check("no_starve", 32'(wait_cnt[k] <= N - 1), 32'd1);
          end
        end
        wait_cnt[i] = 0;
        glog.push_back(i);
        if (auto_drop) v[i] = 1'b0;
      end
    end
    if (w >= 0) begin
      last_acc = cyc;
      exp_data = d[w*DW +: DW];
      exp_gid  = 32'(w);
      ptr      = (w + 1) % N;
      start_at = cyc + 1;
      if (never_busy) begin
        to_at   = cyc + 2 + TO;
        free_at = cyc + 2 + TO + GAP;
      end else begin
        free_at = cyc + 3 + BUSY_LEN + GAP;
      end
    end
    if (!rst_n) begin
      free_at  = cyc;
      start_at = -1;
      to_at    = -1;
      ptr      = 0;
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (glog.size() < n && k < budget) begin
      step();
      k++;
    end
    check("grants_seen", 32'(glog.size()), 32'(n));
  endtask

  task automatic drain();
    int k = 0;
    while ((cyc < free_at || cyc <= busy_to) && k < 200) begin
      step();
      k++;
    end
    check("drained", 32'(cyc >= free_at && cyc > busy_to), 32'd1);
  endtask

  task automatic do_reset();
    v = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    glog.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    rst_n     = 1'b0;
    tx_busy   = 1'b0;
    req_valid = '1;
    req_data  = '0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    do_reset();

    // Single requester, single byte.
    d = 32'h0000_0055;
    v = 4'b0001;
    wait_grants(1, 50);
    if (glog.size() > 0) check("t1_winner", 32'(glog[0]), 32'd0);
    drain();

    // All four held: order 0,1,2,3,0 with the gap enforced between frames.
    do_reset();
    auto_drop = 1'b0;
    d = 32'hA3A2_A1A0;
    v = 4'b1111;
    wait_grants(5, 200);
    for (int i = 0; i < glog.size() && i < 5; i++) check("t2_order", 32'(glog[i]), 32'(i % N));
    auto_drop = 1'b1;
    v = '0;
    drain();

    // Pointer at 3 with 0 and 3 requesting: 3, then 0, then pointer sits at 1.
    do_reset();
    d = 32'h1122_3344;
    v = 4'b0100;
    wait_grants(1, 50);
    v = 4'b1001;
    wait_grants(3, 100);
    v = 4'b0011;
    wait_grants(4, 100);
    if (glog.size() == 4) begin
      check("t3_first", 32'(glog[1]), 32'd3);
      check("t3_wrap", 32'(glog[2]), 32'd0);
      check("t3_ptr1", 32'(glog[3]), 32'd1);
    end
    v = '0;
    drain();

    // Transmitter never goes busy: timeout on each frame, scheduler keeps going.
    never_busy = 1'b1;
    n_to = 0;
    glog.delete();
    v = 4'b0001;
    wait_grants(1, 50);
    v = 4'b0010;
    wait_grants(2, 100);
    drain();
    check("t4_timeouts", 32'(n_to), 32'd2);
    never_busy = 1'b0;

    // Reset while waiting for the frame to finish.
    do_reset();
    v = 4'b0100;
    wait_grants(1, 50);
    while (cyc < last_acc + 5) step();
    check("t5_busy_high", 32'(tx_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    check("t5_rst_start", 32'(tx_start), 32'd0);
    check("t5_rst_data", 32'(tx_data), 32'd0);
    check("t5_rst_gid", 32'(grant_id), 32'd0);
    check("t5_rst_active", 32'(active), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    glog.delete();
    v = 4'b0010;
    wait_grants(1, 50);
    check("t5_after_busy", 32'(last_acc > busy_to), 32'd1);
    drain();

    // Random producers that mostly hold valid until accepted, sometimes withdraw.
    for (int c = 0; c < 8000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(3) == 0) begin
          v[i] = 1'b1;
          d[i*DW +: DW] = 8'($urandom);
        end else if (v[i] && $urandom_range(63) == 0) begin
          v[i] = 1'b0;
        end
      end
      step();
    end
    v = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
